// File: rtl/seg_display_mux.sv
// Time-multiplexed seven-segment driver: scans one digit per refresh slot from a
// display register that only takes new values at frame boundaries (tear-free).
module seg_display_mux #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_flag_q, pend_flag_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q;

  logic tick, wrap_tick;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0: g = 7'b0111111;
      4'h1: g = 7'b0000110;
      4'h2: g = 7'b1011011;
      4'h3: g = 7'b1001111;
      4'h4: g = 7'b1100110;
      4'h5: g = 7'b1101101;
      4'h6: g = 7'b1111101;
      4'h7: g = 7'b0000111;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1101111;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b1111100;
      4'hC: g = 7'b0111001;
      4'hD: g = 7'b1011110;
      4'hE: g = 7'b1111001;
      default: g = 7'b1110001;
    endcase
    if (code > 4'd9 && HEX_MODE == 0) g = 7'b0000000;
    return g;
  endfunction

  assign tick      = (cnt_q == CNT_MAX);
  assign wrap_tick = tick && (idx_q == IDX_MAX);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    disp_val_d  = disp_val_q;
    disp_dp_d   = disp_dp_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    if (wrap_tick) begin
      // A load coinciding with the boundary wins over anything still pending.
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
      end else if (pend_flag_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_flag_d = 1'b0;
    end else if (load) begin
      pend_val_d  = value;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end
  end

  logic [3:0]        code;
  logic              dp_bit;
  logic              zero_run;
  logic              blank;
  logic [6:0]        seg_lit;
  logic [DIGITS-1:0] an_lit;

  always_comb begin
    code     = '0;
    dp_bit   = 1'b0;
    blank    = 1'b0;
    zero_run = blank_lz;
    an_lit   = '0;
    // zero_run stays set while digit i and every digit above it are zero.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run  = zero_run && (disp_val_q[4*i +: 4] == 4'd0);
      an_lit[i] = (IDX_W'(i) == idx_q);
      if (IDX_W'(i) == idx_q) begin
        code   = disp_val_q[4*i +: 4];
        dp_bit = disp_dp_q[i];
        blank  = zero_run && (i != 0);
      end
    end
    seg_lit = blank ? 7'b0000000 : glyph(code);
    seg_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
    dp_d    = (SEG_ACTIVE_LOW != 0) ? ~dp_bit : dp_bit;
    an_d    = (AN_ACTIVE_LOW != 0) ? ~an_lit : an_lit;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: every register here, including the value stores, is reset so a mid-frame reset leaves no stale digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      disp_val_q  <= '0;
      disp_dp_q   <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pend_flag_q <= 1'b0;
      seg_q       <= SEG_OFF;
      dp_q        <= DP_OFF;
      an_q        <= AN_OFF;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_val_q  <= disp_val_d;
      disp_dp_q   <= disp_dp_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      frame_q     <= wrap_tick;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux: decimal and hex instances share stimulus and are
// compared every cycle against an arithmetic model, plus literal pin checks.
module tb_seg_display_mux;

  localparam int D = 4;
  localparam int R = 4;
  localparam int FRAME_LEN = D * R;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic          blank_lz;
  logic [6:0]    seg_dec, seg_hex;
  logic          dp_dec, dp_hex;
  logic [3:0]    an_dec, an_hex;
  logic          frame_dec, frame_hex;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_display_mux #(.DIGITS(D), .REFRESH_DIV(R), .HEX_MODE(0),
                    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u_dec (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg_dec), .dp(dp_dec), .an(an_dec), .frame(frame_dec));

  seg_display_mux #(.DIGITS(D), .REFRESH_DIV(R), .HEX_MODE(1),
                    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u_hex (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg_hex), .dp(dp_hex), .an(an_hex), .frame(frame_hex));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Active-high glyphs {g..a}, codes 0..F.
  localparam logic [6:0] GLYPH [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  function automatic logic [6:0] model_seg(input logic [15:0] disp, input int idx,
                                           input logic blz, input bit hex);
    logic [3:0] c;
    c = disp[4*idx +: 4];
    if (blz && idx != 0 && (disp >> (4*idx)) == 16'd0) return 7'h7F;
    if (c > 4'd9 && !hex) return 7'h7F;
    return ~GLYPH[c];
  endfunction

  // Model: edges since reset release give the slot; display value changes only at frame edges.
  int          m_k = 0;
  logic [15:0] m_disp = '0;
  logic [3:0]  m_dp = '0;
  logic [15:0] m_pend = '0;
  logic [3:0]  m_pend_dp = '0;
  bit          m_pend_v = 0;
  logic [6:0]  e_seg_dec = 7'h7F, e_seg_hex = 7'h7F;
  logic        e_dp = 1'b1, e_frame = 1'b0;
  logic [3:0]  e_an = 4'hF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_disp = '0; m_dp = '0; m_pend = '0; m_pend_dp = '0; m_pend_v = 0;
      e_seg_dec = 7'h7F; e_seg_hex = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_frame = 1'b0;
    end else begin
      int k, idx;
      bit wrap;
      k   = m_k + 1;
      idx = ((k - 1) / R) % D;
      e_seg_dec = model_seg(m_disp, idx, blank_lz, 1'b0);
      e_seg_hex = model_seg(m_disp, idx, blank_lz, 1'b1);
      e_dp      = ~m_dp[idx];
      e_an      = ~(4'b0001 << idx);
      wrap      = (k % FRAME_LEN) == 0;
      e_frame   = wrap;
      if (wrap) begin
        if (load) begin
          m_disp = value; m_dp = dp_in;
        end else if (m_pend_v) begin
          m_disp = m_pend; m_dp = m_pend_dp;
        end
        m_pend_v = 0;
      end else if (load) begin
        m_pend = value; m_pend_dp = dp_in; m_pend_v = 1;
      end
      m_k = k;
    end
  end

  always @(negedge clk) begin
    check("model dec seg", seg_dec, e_seg_dec);
    check("model hex seg", seg_hex, e_seg_hex);
    check("model dec dp", dp_dec, e_dp);
    check("model hex dp", dp_hex, e_dp);
    check("model dec an", an_dec, e_an);
    check("model hex an", an_hex, e_an);
    check("model dec frame", frame_dec, e_frame);
    check("model hex frame", frame_hex, e_frame);
  end

  task automatic wait_an(input logic [3:0] target, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an_dec !== target && n < 64);
    check({name, " reached"}, an_dec, target);
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_dec !== 1'b1 && n < 64);
    check({name, " frame seen"}, frame_dec, 1'b1);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; value = v; dp_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nf, guard;
    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    check("reset seg", seg_dec, 7'h7F);
    check("reset an", an_dec, 4'hF);
    check("reset dp", dp_dec, 1'b1);
    check("reset frame", frame_dec, 1'b0);
    rst_n = 1'b1;

    // Idle scan: digit 0 shows "0", one frame pulse per 16 clocks.
    wait_an(4'b1110, "idle d0");
    check("idle d0 seg", seg_dec, 7'b1000000);
    nf = 0;
    repeat (64) begin
      @(negedge clk);
      if (frame_dec) nf++;
    end
    check("frames in 64 clks", nf, 4);

    // Mid-frame load is held back until the boundary.
    wait_frame("t2");
    pulse_load(16'h1234, 4'b0000);
    wait_an(4'b0111, "t2 old d3");
    check("t2 d3 before commit", seg_dec, 7'b1000000);
    wait_an(4'b1110, "t2 d0");
    check("t2 d0 shows 4", seg_dec, 7'b0011001);
    wait_an(4'b0111, "t2 d3");
    check("t2 d3 shows 1", seg_dec, 7'b1111001);

    // Last pending load wins.
    wait_frame("t3");
    pulse_load(16'h0012, 4'b0000);
    repeat (3) @(negedge clk);
    pulse_load(16'h0056, 4'b0000);
    wait_frame("t3 commit");
    wait_an(4'b1110, "t3 d0");
    check("t3 d0 shows 6", seg_dec, 7'b0000010);
    wait_an(4'b1101, "t3 d1");
    check("t3 d1 shows 5", seg_dec, 7'b0010010);

    // Leading-zero blanking with a dp on a blanked digit.
    blank_lz = 1'b1;
    pulse_load(16'h0005, 4'b0100);
    wait_frame("t4");
    wait_an(4'b1110, "t4 d0");
    check("t4 d0 seg", seg_dec, 7'b0010010);
    check("t4 d0 dp", dp_dec, 1'b1);
    wait_an(4'b1101, "t4 d1");
    check("t4 d1 seg", seg_dec, 7'b1111111);
    check("t4 d1 dp", dp_dec, 1'b1);
    wait_an(4'b1011, "t4 d2");
    check("t4 d2 seg", seg_dec, 7'b1111111);
    check("t4 d2 dp", dp_dec, 1'b0);
    wait_an(4'b0111, "t4 d3");
    check("t4 d3 seg", seg_dec, 7'b1111111);
    check("t4 d3 dp", dp_dec, 1'b1);

    // Hex glyphs versus blanked codes.
    blank_lz = 1'b0;
    pulse_load(16'hABCD, 4'b0000);
    wait_frame("t5");
    wait_an(4'b1110, "t5 d0");
    check("t5 hex d0 d", seg_hex, 7'b0100001);
    check("t5 dec d0 blank", seg_dec, 7'b1111111);
    wait_an(4'b0111, "t5 d3");
    check("t5 hex d3 A", seg_hex, 7'b0001000);
    check("t5 dec d3 blank", seg_dec, 7'b1111111);

    // Load on the wrap_tick cycle commits at once.
    guard = 0;
    while (((m_k + 1) % FRAME_LEN) != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("t6 aligned to wrap", (m_k + 1) % FRAME_LEN, 0);
    pulse_load(16'h9999, 4'b0000);
    check("t6 frame on commit", frame_dec, 1'b1);
    wait_an(4'b1110, "t6 d0");
    check("t6 d0 shows 9", seg_dec, 7'b0010000);

    // Pending load discarded by a mid-slot reset.
    pulse_load(16'h7777, 4'b1111);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async seg", seg_dec, 7'h7F);
    check("t6 async an", an_dec, 4'hF);
    check("t6 async dp", dp_dec, 1'b1);
    check("t6 async frame", frame_dec, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_an(4'b1110, "t6 post reset d0");
    check("t6 post reset d0 is 0", seg_dec, 7'b1000000);
    wait_frame("t6 post reset");
    wait_an(4'b1110, "t6 after frame d0");
    check("t6 pending discarded", seg_dec, 7'b1000000);
    check("t6 dp discarded", dp_dec, 1'b1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
Parametrised, time-multiplexed driver for a common-anode/cathode multi-digit seven-segment display. It latches a packed multi-digit value with per-digit decimal points and scans one digit per refresh slot. Decoding supports BCD or hex glyphs, optional leading-zero blanking and configurable output polarity. Updates are tear-free: new values take effect only at a frame boundary. It sits between the datapath producing numeric results and the board display pins, replacing single-digit per-cycle decoders.

Parameters:
DIGITS, 4, number of digits scanned (>=1)
REFRESH_DIV, 50000, clk cycles per digit slot (>=1)
HEX_MODE, 0, 1 = codes 10-15 show A,b,C,d,E,F; 0 = codes 10-15 blank
SEG_ACTIVE_LOW, 1, 1 = seg/dp driven low to light
AN_ACTIVE_LOW, 1, 1 = an driven low to enable a digit

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
load  in  1  capture value/dp_in this cycle
value  in  4*DIGITS  digit i = value[4i+3:4i], digit 0 least significant
dp_in  in  DIGITS  decimal point for digit i
blank_lz  in  1  1 = suppress leading zeros (sampled live, not latched)
seg  out  7  segments {g,f,e,d,c,b,a}, bit0 = a
dp  out  1  decimal point of currently scanned digit
an  out  DIGITS  digit enables, one-hot (polarity per AN_ACTIVE_LOW)
frame  out  1  one-cycle pulse when a new frame starts (display register commit point)

Behaviour:
- Reset (async assert, sync release): prescaler=0, index=0, display reg=0, dp reg=0, pending reg/flag=0; seg all unlit, dp unlit, an all disabled, frame=0.
- Prescaler counts 0..REFRESH_DIV-1, wraps to 0; tick=1 when count==REFRESH_DIV-1. REFRESH_DIV=1: tick every cycle.
- On tick: index increments, wraps DIGITS-1 -> 0. wrap_tick = tick && index==DIGITS-1. DIGITS=1: every tick is wrap_tick.
- load without wrap_tick: pending <= value/dp_in, pending flag=1; later load before commit overwrites (last wins).
- wrap_tick: if load same cycle, display reg <= value/dp_in directly, flag cleared; else if flag set, display reg <= pending, flag cleared; else display reg unchanged. frame=1 in the cycle following wrap_tick (registered), else 0.
- Outputs registered: each cycle seg/dp/an computed from current index and display reg; latency 1 cycle from index change to pins. an enables only bit index.
- Glyphs, active-high internal {g..a}: 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101 6=1111101 7=0000111 8=1111111 9=1101111; A=1110111 b=1111100 C=0111001 d=1011110 E=1111001 F=1110001 (HEX_MODE=1); 10-15 blank when HEX_MODE=0. SEG_ACTIVE_LOW inverts seg and dp.
- Leading-zero blanking: if blank_lz=1, digit i is blanked when its code and all higher digits' codes are 0; digit 0 never blanked. Blanked digit's dp still follows dp reg. Evaluated on display reg, not pending.
- Reset mid-frame: pending load discarded, display returns to 0, scan restarts at digit 0.

Test Plan:
- DIGITS=4, REFRESH_DIV=4, defaults; release reset, no load -> an cycles 1110,1101,1011,0111 every 4 clks, seg=1000000 (digit "0") throughout, frame pulses once per 16 clks.
- load value=16'h1234 mid-frame -> pins unchanged until next frame pulse; then an=1110 shows seg=0011001 ("4"), an=0111 shows seg=1111001 ("1").
- load 16'h0012 then 16'h0056 before boundary -> after commit digit0 shows "6" (0000010), digit1 "5" (0010010); 16'h0012 never displayed.
- value=16'h0005, blank_lz=1, dp_in=4'b0100 -> digits 3,1 seg=1111111, dp=1; digit 2 seg=1111111, dp=0 (lit); digit 0 shows "5".
- HEX_MODE=1, value=16'hABCD -> digit0 seg=0100001 ("d"), digit3 seg=0001000 ("A"); HEX_MODE=0 same value -> all seg=1111111.
- load asserted on wrap_tick cycle with 16'h9999 -> committed immediately, digit0 on next scan shows 0010000; assert rst_n=0 mid-slot -> seg=1111111, an=1111 immediately, display reg=0.
